// File: rtl/stream_width_converter_pkg.sv
// Shared definitions for the stream width converter: state encoding,
// common stream widths and the counter-width helper.
package stream_width_converter_pkg;

  localparam int BYTE_LEN = 8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } swc_state_e;

  // Bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/stream_width_converter.sv
// LSB-first stream width converter with downstream backpressure, end-of-stream
// draining, optional zero padding of the final partial word and truncation flag.
module stream_width_converter
  import stream_width_converter_pkg::*;
#(
  parameter int IN_LEN    = BYTE_LEN,
  parameter int OUT_LEN   = 2,
  parameter bit PAD_FINAL = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               inclk,
  input  logic [IN_LEN-1:0]  in,
  input  logic               in_done,
  input  logic               downstream_rdy,
  output logic               rdy,
  output logic               outclk,
  output logic [OUT_LEN-1:0] out,
  output logic               done,
  output logic               trunc
);

  localparam int BUF_LEN = IN_LEN + OUT_LEN - 1;
  localparam int CNT_W   = clog2(BUF_LEN + 1);
  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_LEN);
  localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_LEN);

  swc_state_e         state;
  swc_state_e         state_nxt;
  logic [BUF_LEN-1:0] buf_q;
  logic [BUF_LEN-1:0] buf_shift;
  logic [BUF_LEN-1:0] buf_nxt;
  logic [BUF_LEN-1:0] in_ext;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next_base;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               trunc_pend;
  logic               trunc_pend_nxt;
  logic               full;
  logic               fire;
  logic               pad_fire;
  logic               accept;

  // Bits above cnt in buf_q are always zero, so new words can be OR-ed in
  // and a padded final word needs no explicit masking.
  always_comb begin
    full          = (cnt >= OUT_CNT);
    fire          = full && downstream_rdy && (state != ST_FIN);
    cnt_next_base = fire ? (cnt - OUT_CNT) : cnt;
    rdy           = rstn && (state == ST_RUN) && (cnt_next_base < OUT_CNT);
    accept        = inclk && rdy;
    pad_fire      = PAD_FINAL && (state == ST_DRAIN) && !full &&
                    (cnt != '0) && downstream_rdy;
    in_ext        = BUF_LEN'(in);
    buf_shift     = fire ? (buf_q >> OUT_LEN) : buf_q;
    buf_nxt       = buf_shift | (accept ? (in_ext << cnt_next_base) : '0);
    cnt_nxt       = cnt_next_base + (accept ? IN_CNT : '0);
  end

  always_comb begin
    state_nxt      = state;
    trunc_pend_nxt = trunc_pend;
    case (state)
      ST_RUN: begin
        if (in_done) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A full word that empties the buffer finishes the stream directly,
        // so done always lands one cycle after the last outclk.
        if (fire) begin
          if (cnt_next_base == '0) state_nxt = ST_FIN;
        end else if (!full) begin
          if (cnt == '0) begin
            state_nxt = ST_FIN;
          end else if (PAD_FINAL) begin
            if (downstream_rdy) state_nxt = ST_FIN;
          end else begin
            trunc_pend_nxt = 1'b1;
            state_nxt      = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        trunc_pend_nxt = 1'b0;
        state_nxt      = ST_RUN;
      end
      default: begin
        trunc_pend_nxt = 1'b0;
        state_nxt      = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_RUN;
      trunc_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      trunc_pend <= trunc_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      buf_q  <= '0;
      out    <= '0;
      outclk <= 1'b0;
      done   <= 1'b0;
      trunc  <= 1'b0;
    end else begin
      outclk <= fire || pad_fire;
      if (fire || pad_fire) out <= buf_q[OUT_LEN-1:0];
      done  <= (state == ST_FIN);
      trunc <= (state == ST_FIN) && trunc_pend;
      if (state == ST_FIN) begin
        cnt   <= '0;
        buf_q <= '0;
      end else begin
        cnt   <= cnt_nxt;
        buf_q <= buf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_stream_width_converter.sv
// Scoreboard bench for stream_width_converter: four instances (8->2, 2->8,
// 8->12 padded, 8->12 truncating) driven with hand-computed directed vectors.
module tb_stream_width_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        inclk   [4];
  logic [15:0] din     [4];
  logic        in_done [4];
  logic        drdy    [4];
  logic        rdy_o   [4];
  logic        oc      [4];
  logic        dn      [4];
  logic        tr      [4];
  logic [15:0] ov      [4];
  logic [1:0]  out0;
  logic [7:0]  out1;
  logic [11:0] out2;
  logic [11:0] out3;

  assign ov[0] = {14'b0, out0};
  assign ov[1] = {8'b0, out1};
  assign ov[2] = {4'b0, out2};
  assign ov[3] = {4'b0, out3};

  stream_width_converter #(.IN_LEN(8), .OUT_LEN(2), .PAD_FINAL(1'b1)) u_8to2 (
    .clk(clk), .rstn(rstn), .inclk(inclk[0]), .in(din[0][7:0]), .in_done(in_done[0]),
    .downstream_rdy(drdy[0]), .rdy(rdy_o[0]), .outclk(oc[0]), .out(out0),
    .done(dn[0]), .trunc(tr[0]));

  stream_width_converter #(.IN_LEN(2), .OUT_LEN(8), .PAD_FINAL(1'b1)) u_2to8 (
    .clk(clk), .rstn(rstn), .inclk(inclk[1]), .in(din[1][1:0]), .in_done(in_done[1]),
    .downstream_rdy(drdy[1]), .rdy(rdy_o[1]), .outclk(oc[1]), .out(out1),
    .done(dn[1]), .trunc(tr[1]));

  stream_width_converter #(.IN_LEN(8), .OUT_LEN(12), .PAD_FINAL(1'b1)) u_8to12p (
    .clk(clk), .rstn(rstn), .inclk(inclk[2]), .in(din[2][7:0]), .in_done(in_done[2]),
    .downstream_rdy(drdy[2]), .rdy(rdy_o[2]), .outclk(oc[2]), .out(out2),
    .done(dn[2]), .trunc(tr[2]));

  stream_width_converter #(.IN_LEN(8), .OUT_LEN(12), .PAD_FINAL(1'b0)) u_8to12t (
    .clk(clk), .rstn(rstn), .inclk(inclk[3]), .in(din[3][7:0]), .in_done(in_done[3]),
    .downstream_rdy(drdy[3]), .rdy(rdy_o[3]), .outclk(oc[3]), .out(out3),
    .done(dn[3]), .trunc(tr[3]));

  typedef struct packed {
    logic [1:0]  dut;
    logic        is_done;
    logic [15:0] val;
    logic [7:0]  gap;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_oc [4];
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pw(input int d, input logic [15:0] v, input int gap);
    exp_t e;
    e.dut = d[1:0]; e.is_done = 1'b0; e.val = v; e.gap = gap[7:0];
    sbq.push_back(e);
  endtask

  task automatic pd(input int d, input logic t, input int gap);
    exp_t e;
    e.dut = d[1:0]; e.is_done = 1'b1; e.val = {15'b0, t}; e.gap = gap[7:0];
    sbq.push_back(e);
  endtask

  task automatic send(input int d, input logic [15:0] v, input logic last, input logic must_rdy);
    int n = 0;
    while (rdy_o[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk($sformatf("rdy_wait_d%0d", d), rdy_o[d], 1);
    if (must_rdy) chk($sformatf("rdy_held_d%0d", d), n, 0);
    din[d] = v; inclk[d] = 1'b1; in_done[d] = last;
    tick();
    inclk[d] = 1'b0; in_done[d] = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon_dut(input int d);
    int   idx;
    exp_t e;
    if (oc[d] === 1'b1 || dn[d] === 1'b1) begin
      idx = -1;
      for (int i = 0; i < sbq.size(); i++)
        if (idx < 0 && sbq[i].dut == d[1:0]) idx = i;
      if (idx < 0) begin
        chk($sformatf("unexpected_evt_d%0d", d), {30'b0, oc[d], dn[d]}, 0);
      end else begin
        e = sbq[idx];
        sbq.delete(idx);
        if (oc[d] === 1'b1) begin
          chk($sformatf("kind_word_d%0d", d), e.is_done, 0);
          chk($sformatf("data_d%0d", d), ov[d], e.val);
          if (e.gap != 0) chk($sformatf("word_gap_d%0d", d), cyc - last_oc[d], e.gap);
          last_oc[d] = cyc;
        end else begin
          chk($sformatf("kind_done_d%0d", d), e.is_done, 1);
          chk($sformatf("done_trunc_d%0d", d), tr[d], e.val[0]);
          if (e.gap != 0) chk($sformatf("done_gap_d%0d", d), cyc - last_oc[d], e.gap);
        end
      end
    end
    if (dn[d] !== 1'b1) chk($sformatf("trunc_idle_d%0d", d), tr[d], 0);
  endtask

  always @(negedge clk) begin
    if (mon_en)
      for (int d = 0; d < 4; d++) mon_dut(d);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < 4; d++) begin
      inclk[d] = 1'b0; din[d] = '0; in_done[d] = 1'b0; drdy[d] = 1'b1; last_oc[d] = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_out_d%0d", d), ov[d], 0);
      chk($sformatf("rst_outclk_d%0d", d), oc[d], 0);
      chk($sformatf("rst_done_d%0d", d), dn[d], 0);
      chk($sformatf("rst_trunc_d%0d", d), tr[d], 0);
      chk($sformatf("rst_rdy_d%0d", d), rdy_o[d], 0);
    end
    rstn = 1'b1;
    tick();
    mon_en = 1'b1;
    for (int d = 0; d < 4; d++) chk($sformatf("post_rst_rdy_d%0d", d), rdy_o[d], 1);

    // 8->2: 0xD5 with in_done on the same edge
    pw(0, 16'h1, 0); pw(0, 16'h1, 1); pw(0, 16'h1, 1); pw(0, 16'h3, 1); pd(0, 1'b0, 1);
    send(0, 16'hD5, 1'b1, 1'b1);
    repeat (8) tick();

    // 2->8: two bytes of 0xD5 with rdy held throughout
    pw(1, 16'hD5, 0); pw(1, 16'hD5, 4); pd(1, 1'b0, 1);
    for (int i = 0; i < 8; i++)
      send(1, (i % 4 == 3) ? 16'h3 : 16'h1, (i == 7), 1'b1);
    repeat (8) tick();

    // 8->12 padded: exact multiple
    pw(2, 16'hAFE, 0); pw(2, 16'hEFC, 1); pw(2, 16'hDBE, 2); pw(2, 16'hDEA, 1);
    pd(2, 1'b0, 1);
    send(2, 16'hFE, 1'b0, 1'b1); send(2, 16'hCA, 1'b0, 1'b1);
    send(2, 16'hEF, 1'b0, 1'b1); send(2, 16'hBE, 1'b0, 1'b1);
    send(2, 16'hAD, 1'b0, 1'b1); send(2, 16'hDE, 1'b1, 1'b1);
    repeat (8) tick();

    // 8->12 padded: 24 bits, no residual
    pw(2, 16'h234, 0); pw(2, 16'hFF1, 1); pd(2, 1'b0, 1);
    send(2, 16'h34, 1'b0, 1'b1); send(2, 16'h12, 1'b0, 1'b1); send(2, 16'hFF, 1'b1, 1'b1);
    repeat (8) tick();

    // 8->12 padded: 4 residual bits become 0x00F
    pw(2, 16'hFFF, 0); pw(2, 16'h00F, 1); pd(2, 1'b0, 1);
    send(2, 16'hFF, 1'b0, 1'b1); send(2, 16'hFF, 1'b1, 1'b1);
    repeat (8) tick();

    // 8->12 truncating: 4 residual bits dropped, trunc with done
    pw(3, 16'hFFF, 0); pd(3, 1'b1, 2);
    send(3, 16'hFF, 1'b0, 1'b1); send(3, 16'hFF, 1'b1, 1'b1);
    repeat (8) tick();

    // 8->12 truncating: no residual, trunc stays low
    pw(3, 16'h234, 0); pw(3, 16'hFF1, 1); pd(3, 1'b0, 1);
    send(3, 16'h34, 1'b0, 1'b1); send(3, 16'h12, 1'b0, 1'b1); send(3, 16'hFF, 1'b1, 1'b1);
    repeat (8) tick();

    // 8->2 backpressure: 0x1B -> 11,10,01,00 with a two-cycle stall
    pw(0, 16'h3, 0); pw(0, 16'h2, 3); pw(0, 16'h1, 1); pw(0, 16'h0, 1); pd(0, 1'b0, 3);
    din[0] = 16'h1B; inclk[0] = 1'b1;
    tick();
    inclk[0] = 1'b0;
    chk("full_rdy_low", rdy_o[0], 0);
    tick();
    drdy[0] = 1'b0;
    #1;
    chk("stall_rdy_low", rdy_o[0], 0);
    tick();
    chk("stall1_out_held", ov[0], 3);
    chk("stall1_outclk", oc[0], 0);
    tick();
    chk("stall2_out_held", ov[0], 3);
    chk("stall2_outclk", oc[0], 0);
    drdy[0] = 1'b1;
    tick();
    chk("cnt4_rdy_low", rdy_o[0], 0);
    tick();
    chk("cnt2_rdy_high", rdy_o[0], 1);
    tick();
    in_done[0] = 1'b1;
    tick();
    in_done[0] = 1'b0;
    repeat (8) tick();

    // 8->2 reset with 6 bits buffered, then a clean 0xAA stream
    pw(0, 16'h3, 0);
    din[0] = 16'hFF; inclk[0] = 1'b1;
    tick();
    inclk[0] = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    chk("mid_rst_outclk", oc[0], 0);
    chk("mid_rst_rdy", rdy_o[0], 0);
    chk("mid_rst_done", dn[0], 0);
    chk("mid_rst_out", ov[0], 0);
    rstn = 1'b1;
    tick();
    pw(0, 16'h2, 0); pw(0, 16'h2, 1); pw(0, 16'h2, 1); pw(0, 16'h2, 1); pd(0, 1'b0, 1);
    send(0, 16'hAA, 1'b1, 1'b1);
    repeat (10) tick();

    chk("scoreboard_leftover", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
